// File: rtl/line_memory_pkg.sv
// Shared types and constants for the line_memory block: FSM states, line offset
// and the default geometry/latency.
package line_memory_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK
    } state_e;

    localparam int LINE_OFFSET        = 5;
    localparam int DEFAULT_DATA_WIDTH = 256;
    localparam int DEFAULT_DEPTH      = 512;
    localparam int DEFAULT_DELAY      = 10;

endpackage

// File: rtl/line_memory_array.sv
// Line storage for line_memory: one synchronous write port, one asynchronous
// read port, no reset so contents survive a block reset.
module line_memory_array #(
    parameter int DATA_WIDTH = 256,
    parameter int DEPTH      = 512,
    parameter int INDEX_W    = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [INDEX_W-1:0]    waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [INDEX_W-1:0]    raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] memory [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we) begin
            memory[waddr] <= wdata;
        end
    end

    assign rdata = memory[raddr];

endmodule

// File: rtl/line_memory.sv
// Fixed-latency line memory: captures one request, acks DELAY cycles later.
// Optional LINE_MEMORY_RDATA_HOLD_EN keeps data_o at the last read line.
module line_memory
    import line_memory_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int DELAY      = DEFAULT_DELAY
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           addr_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  enable_i,
    input  logic                  write_i,
    output logic                  ack_o,
    output logic [DATA_WIDTH-1:0] data_o
);

    localparam int INDEX_W = $clog2(DEPTH);

    state_e                state, state_next;
    logic [7:0]            count, count_next;
    logic [INDEX_W-1:0]    index_q, addr_index, txn_index;
    logic [DATA_WIDTH-1:0] data_q, txn_data, rdata;
    logic                  write_q, txn_write;
    logic                  capture, enter_ack, we;
    logic                  unused_addr;

    assign addr_index  = addr_i[LINE_OFFSET +: INDEX_W];
    assign unused_addr = ^{addr_i[31:LINE_OFFSET+INDEX_W], addr_i[LINE_OFFSET-1:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    always_comb begin
        state_next = state;
        count_next = count;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (enable_i) begin
                    capture    = 1'b1;
                    count_next = 8'(DELAY - 1);
                    state_next = (DELAY == 1) ? ACK : WAIT;
                end
            end
            WAIT: begin
                count_next = count - 8'd1;
                if (count == 8'd1) begin
                    state_next = ACK;
                end
            end
            ACK: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // With DELAY=1 the ACK entry coincides with capture, so the array ports
    // must see the live request rather than the (not yet) latched copy.
    assign txn_index = (state == IDLE) ? addr_index : index_q;
    assign txn_data  = (state == IDLE) ? data_i     : data_q;
    assign txn_write = (state == IDLE) ? write_i    : write_q;
    assign enter_ack = (state_next == ACK) && (state != ACK);
    assign we        = enter_ack && txn_write;
    assign ack_o     = (state == ACK);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            index_q <= '0;
            data_q  <= '0;
            write_q <= 1'b0;
        end else if (capture) begin
            index_q <= addr_index;
            data_q  <= data_i;
            write_q <= write_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_o <= '0;
        end else if (enter_ack && !txn_write) begin
            data_o <= rdata;
        end
`ifndef LINE_MEMORY_RDATA_HOLD_EN
        else begin
            data_o <= '0;
        end
`endif
    end

    line_memory_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .INDEX_W    (INDEX_W)
    ) u_array (
        .clk   (clk),
        .we    (we),
        .waddr (txn_index),
        .wdata (txn_data),
        .raddr (txn_index),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_line_memory.sv
// Directed self-checking bench for line_memory (DELAY=10 and DELAY=1 instances);
// honours LINE_MEMORY_RDATA_HOLD_EN in its expectations.
module tb_line_memory;
    import line_memory_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    int           cyc = 0;
    int           errors = 0;
    int           checks = 0;

    logic [31:0]  a_addr = '0;
    logic [255:0] a_data = '0;
    logic         a_en = 1'b0, a_wr = 1'b0, a_ack;
    logic [255:0] a_rdata;

    logic [31:0]  b_addr = '0;
    logic [255:0] b_data = '0;
    logic         b_en = 1'b0, b_wr = 1'b0, b_ack;
    logic [255:0] b_rdata;

`ifdef LINE_MEMORY_RDATA_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    localparam logic [255:0] P0 = 256'h5;
    localparam logic [255:0] P2 = 256'hC0FFEE;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    line_memory #(.DATA_WIDTH(256), .DEPTH(512), .DELAY(10)) dut (
        .clk(clk), .rst(rst), .addr_i(a_addr), .data_i(a_data),
        .enable_i(a_en), .write_i(a_wr), .ack_o(a_ack), .data_o(a_rdata)
    );

    line_memory #(.DATA_WIDTH(256), .DEPTH(512), .DELAY(1)) dut1 (
        .clk(clk), .rst(rst), .addr_i(b_addr), .data_i(b_data),
        .enable_i(b_en), .write_i(b_wr), .ack_o(b_ack), .data_o(b_rdata)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One transaction on the DELAY=10 instance; latency counted from the edge
    // before capture. disturb scrambles the inputs right after capture.
    task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [255:0] data,
                           input bit disturb, output int lat, output logic [255:0] rd);
        int start;
        bit seen;
        @(negedge clk);
        a_en = 1'b1; a_wr = wr; a_addr = addr; a_data = data;
        start = cyc; seen = 1'b0; lat = -1; rd = '0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (disturb && i == 0) begin
                a_addr = addr ^ 32'h60; a_data = ~data; a_wr = ~wr;
            end
            if (a_ack) begin
                seen = 1'b1; lat = cyc - start; rd = a_rdata;
            end
        end
        a_en = 1'b0;
        check("ack_seen", 256'(seen), 256'd1);
        @(negedge clk);
        check("ack_one_cycle", 256'(a_ack), 256'd0);
    endtask

    initial begin
        int lat;
        int t1, t2, nack;
        logic [255:0] rd;
        bit pulsed;

        dut.u_array.memory[0]  = P0;
        dut.u_array.memory[2]  = P2;
        dut1.u_array.memory[0] = 256'h7;
        repeat (2) @(negedge clk);
        check("rst_ack", 256'(a_ack), 256'd0);
        check("rst_data", a_rdata, 256'd0);
        check("rst_state", 256'(dut.state), 256'(IDLE));
        rst = 1'b1;
        @(negedge clk);

        run_txn(1'b0, 32'h0, '0, 1'b0, lat, rd);
        check("rd0_lat", 256'(lat), 256'd10);
        check("rd0_data", rd, P0);
        check("rd0_after", a_rdata, HOLD ? P0 : 256'd0);

        run_txn(1'b1, 32'h400, 256'hA5, 1'b0, lat, rd);
        check("wr32_lat", 256'(lat), 256'd10);
        check("wr32_ackdata", rd, HOLD ? P0 : 256'd0);
        check("wr32_mem", dut.u_array.memory[32], 256'hA5);
        run_txn(1'b0, 32'h400, '0, 1'b0, lat, rd);
        check("rd32_data", rd, 256'hA5);

        run_txn(1'b1, 32'h20, 256'hDEADBEEF, 1'b1, lat, rd);
        check("dist_lat", 256'(lat), 256'd10);
        check("dist_mem1", dut.u_array.memory[1], 256'hDEADBEEF);
        check("dist_mem2", dut.u_array.memory[2], P2);

        // Reset in the middle of a write's WAIT phase
        @(negedge clk);
        a_en = 1'b1; a_wr = 1'b1; a_addr = 32'h40; a_data = 256'h1234;
        repeat (4) @(negedge clk);
        check("abort_inwait", 256'(dut.state), 256'(WAIT));
        rst = 1'b0;
        #1;
        check("abort_state", 256'(dut.state), 256'(IDLE));
        check("abort_ack", 256'(a_ack), 256'd0);
        a_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        pulsed = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (a_ack) pulsed = 1'b1;
        end
        check("abort_noack", 256'(pulsed), 256'd0);
        check("abort_mem2", dut.u_array.memory[2], P2);
        check("abort_idle", 256'(dut.state), 256'(IDLE));

        // Read, write, idle: data_o holds or clears depending on build
        run_txn(1'b0, 32'h0, '0, 1'b0, lat, rd);
        check("seq_rd", rd, P0);
        run_txn(1'b1, 32'h400, 256'h77, 1'b0, lat, rd);
        check("seq_wrack", rd, HOLD ? P0 : 256'd0);
        repeat (3) @(negedge clk);
        check("seq_idle", a_rdata, HOLD ? P0 : 256'd0);

        // DELAY=1 instance: single read latency, then back-to-back spacing
        @(negedge clk);
        b_en = 1'b1; b_wr = 1'b0; b_addr = 32'h0;
        t1 = cyc; lat = -1;
        for (int i = 0; i < 10 && lat < 0; i++) begin
            @(negedge clk);
            if (b_ack) begin
                lat = cyc - t1; rd = b_rdata;
            end
        end
        b_en = 1'b0;
        check("d1_lat", 256'(lat), 256'd1);
        check("d1_data", rd, 256'h7);
        @(negedge clk);
        check("d1_after", b_rdata, HOLD ? 256'h7 : 256'd0);

        b_en = 1'b1;
        nack = 0; t1 = -1; t2 = -1;
        for (int i = 0; i < 20 && nack < 2; i++) begin
            @(negedge clk);
            if (b_ack) begin
                if (nack == 0) t1 = cyc; else t2 = cyc;
                nack++;
            end
        end
        b_en = 1'b0;
        check("b2b_count", 256'(nack), 256'd2);
        check("b2b_gap", 256'(t2 - t1), 256'd2);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
